// File: rtl/branch_control_unit.sv
// Decode-stage control-flow unit: jump/branch redirects, CALL/RET through a
// hardware return-address stack, and a single-level interrupt entry/RETI FSM.
module branch_control_unit #(
  parameter int               ADDR_W      = 8,
  parameter int               INS_W       = 24,
  parameter int               FLAG_W      = 4,
  parameter int               STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] ISR_VECTOR = 8'hF0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INS_W-1:0]  ins,
  input  logic              ins_valid,
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [FLAG_W-1:0] flag_ex,
  input  logic              interrupt,
  output logic [ADDR_W-1:0] jmp_loc,
  output logic              pc_mux_sel,
  output logic              flag_restore,
  output logic [FLAG_W-1:0] flag_restore_val,
  output logic              in_isr,
  output logic              stk_overflow,
  output logic              stk_underflow
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [SP_W-1:0]   SP_ONE   = {{(SP_W-1){1'b0}}, 1'b1};
  localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_CALL = 5'b11001;
  localparam logic [4:0] OP_JC   = 5'b11100;
  localparam logic [4:0] OP_JNC  = 5'b11101;
  localparam logic [4:0] OP_JZ   = 5'b11110;
  localparam logic [4:0] OP_JNZ  = 5'b11111;
  localparam logic [4:0] OP_RET  = 5'b10000;
  localparam logic [4:0] OP_RETI = 5'b10001;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ENTER = 2'd1;
  localparam logic [1:0] ST_ISR   = 2'd2;

  logic [1:0]        state_r;
  logic [ADDR_W-1:0] ret_shadow_r;
  logic [FLAG_W-1:0] flag_shadow_r;
  logic [SP_W-1:0]   sp_r;
  logic [ADDR_W-1:0] stack_r [STACK_DEPTH];
  logic              overflow_r;
  logic              underflow_r;

  logic [4:0]        opcode_s;
  logic [ADDR_W-1:0] target_s;
  logic [ADDR_W-1:0] ret_addr_s;
  logic [SP_W-1:0]   top_idx_s;
  logic [ADDR_W-1:0] stack_top_s;
  logic              stk_full_s;
  logic              stk_empty_s;
  logic              sel_s;
  logic [ADDR_W-1:0] loc_s;
  logic              push_s;
  logic              pop_s;
  logic              ovf_set_s;
  logic              unf_set_s;
  logic              reti_s;
  logic              unused_s;

  // Condition evaluation for the unconditional and flag-based jumps.
  function automatic logic branch_taken(input logic [4:0] op, input logic [FLAG_W-1:0] f);
    logic taken;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JC:   taken = f[0];
      OP_JNC:  taken = ~f[0];
      OP_JZ:   taken = f[1];
      OP_JNZ:  taken = ~f[1];
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  assign opcode_s    = ins[INS_W-1 -: 5];
  assign target_s    = ins[ADDR_W-1:0];
  assign ret_addr_s  = cur_addr + ADDR_ONE;
  assign top_idx_s   = sp_r - SP_ONE;
  assign stack_top_s = stack_r[top_idx_s[IDX_W-1:0]];
  assign stk_full_s  = (sp_r == SP_FULL);
  assign stk_empty_s = (sp_r == {SP_W{1'b0}});
  assign unused_s    = ^ins[INS_W-6:ADDR_W];

  // Redirect decision; the ENTER cycle squashes whatever sits in decode.
  always_comb begin
    sel_s     = 1'b0;
    loc_s     = {ADDR_W{1'b0}};
    push_s    = 1'b0;
    pop_s     = 1'b0;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    reti_s    = 1'b0;
    if (reset) begin
      sel_s = 1'b0;
    end else if (state_r == ST_ENTER) begin
      sel_s = 1'b1;
      loc_s = ISR_VECTOR;
    end else if (ins_valid) begin
      case (opcode_s)
        OP_JMP, OP_JC, OP_JNC, OP_JZ, OP_JNZ: begin
          if (branch_taken(opcode_s, flag_ex)) begin
            sel_s = 1'b1;
            loc_s = target_s;
          end else begin
            sel_s = 1'b0;
          end
        end
        OP_CALL: begin
          if (stk_full_s) begin
            ovf_set_s = 1'b1;
          end else begin
            sel_s  = 1'b1;
            loc_s  = target_s;
            push_s = 1'b1;
          end
        end
        OP_RET: begin
          if (stk_empty_s) begin
            unf_set_s = 1'b1;
          end else begin
            sel_s = 1'b1;
            loc_s = stack_top_s;
            pop_s = 1'b1;
          end
        end
        OP_RETI: begin
          // Outside the ISR a RETI has nothing to return to and is a NOP.
          if (state_r == ST_ISR) begin
            sel_s  = 1'b1;
            loc_s  = ret_shadow_r;
            reti_s = 1'b1;
          end else begin
            reti_s = 1'b0;
          end
        end
        default: sel_s = 1'b0;
      endcase
    end else begin
      sel_s = 1'b0;
    end
  end

  // Interrupt FSM and the return/flag shadows captured on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      ret_shadow_r  <= {ADDR_W{1'b0}};
      flag_shadow_r <= {FLAG_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (interrupt) begin
            state_r <= ST_ENTER;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ENTER: begin
          ret_shadow_r  <= cur_addr;
          flag_shadow_r <= flag_ex;
          state_r       <= ST_ISR;
        end
        ST_ISR: begin
          if (reti_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_ISR;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Return-address stack; sp saturates at both ends instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_r <= {SP_W{1'b0}};
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_r[i] <= {ADDR_W{1'b0}};
      end
    end else if (push_s) begin
      stack_r[sp_r[IDX_W-1:0]] <= ret_addr_s;
      sp_r                     <= sp_r + SP_ONE;
    end else if (pop_s) begin
      sp_r <= sp_r - SP_ONE;
    end else begin
      sp_r <= sp_r;
    end
  end

  // Sticky stack error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r | ovf_set_s;
      underflow_r <= underflow_r | unf_set_s;
    end
  end

  assign jmp_loc          = loc_s;
  assign pc_mux_sel       = sel_s;
  assign flag_restore     = reti_s;
  assign flag_restore_val = flag_shadow_r;
  assign in_isr           = (state_r == ST_ISR);
  assign stk_overflow     = overflow_r;
  assign stk_underflow    = underflow_r;

endmodule

// File: tb/tb_branch_control_unit.sv
// Randomized and directed bench for branch_control_unit against a
// queue-based behavioural model of redirects, the return stack and interrupts.
module tb_branch_control_unit;

  localparam logic [4:0] JMP = 5'b11000, CALL = 5'b11001, JC = 5'b11100, JNC = 5'b11101;
  localparam logic [4:0] JZ = 5'b11110, JNZ = 5'b11111, RET = 5'b10000, RETI = 5'b10001;
  localparam logic [4:0] NOP = 5'b00000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] ins;
  logic        ins_valid;
  logic [7:0]  cur_addr;
  logic [3:0]  flag_ex;
  logic        interrupt;
  logic [7:0]  jmp_loc;
  logic        pc_mux_sel;
  logic        flag_restore;
  logic [3:0]  flag_restore_val;
  logic        in_isr;
  logic        stk_overflow;
  logic        stk_underflow;

  int errors = 0;
  int checks = 0;

  // behavioural model
  logic [7:0] m_stack[$];
  bit         m_isr, m_entering, m_ovf, m_unf;
  logic [7:0] m_ret;
  logic [3:0] m_flags;
  logic       exp_sel, exp_rest;
  logic [7:0] exp_loc;

  branch_control_unit dut (
    .clk(clk), .reset(reset), .ins(ins), .ins_valid(ins_valid), .cur_addr(cur_addr),
    .flag_ex(flag_ex), .interrupt(interrupt), .jmp_loc(jmp_loc), .pc_mux_sel(pc_mux_sel),
    .flag_restore(flag_restore), .flag_restore_val(flag_restore_val), .in_isr(in_isr),
    .stk_overflow(stk_overflow), .stk_underflow(stk_underflow)
  );

  always #5 clk = ~clk;

  task automatic model_eval();
    logic [4:0] op;
    op = ins[23:19];
    exp_sel = 1'b0; exp_loc = 8'h00; exp_rest = 1'b0;
    if (reset) begin
      exp_sel = 1'b0;
    end else if (m_entering) begin
      exp_sel = 1'b1; exp_loc = 8'hF0;
    end else if (ins_valid) begin
      if (op == JMP || (op == JC && flag_ex[0]) || (op == JNC && !flag_ex[0]) ||
          (op == JZ && flag_ex[1]) || (op == JNZ && !flag_ex[1])) begin
        exp_sel = 1'b1; exp_loc = ins[7:0];
      end
      if (op == CALL && m_stack.size() < DEPTH) begin
        exp_sel = 1'b1; exp_loc = ins[7:0];
      end
      if (op == RET && m_stack.size() > 0) begin
        exp_sel = 1'b1; exp_loc = m_stack[$];
      end
      if (op == RETI && m_isr) begin
        exp_sel = 1'b1; exp_loc = m_ret; exp_rest = 1'b1;
      end
    end
  endtask

  task automatic model_commit();
    logic [4:0] op;
    bit was_idle;
    op = ins[23:19];
    was_idle = !m_isr && !m_entering;
    if (reset) begin
      m_stack.delete();
      m_isr = 0; m_entering = 0; m_ovf = 0; m_unf = 0; m_ret = 8'h00; m_flags = 4'h0;
    end else if (m_entering) begin
      m_ret = cur_addr; m_flags = flag_ex; m_entering = 0; m_isr = 1;
    end else begin
      if (ins_valid && op == CALL) begin
        if (m_stack.size() < DEPTH) m_stack.push_back(8'(cur_addr + 8'd1));
        else m_ovf = 1;
      end
      if (ins_valid && op == RET) begin
        if (m_stack.size() > 0) void'(m_stack.pop_back());
        else m_unf = 1;
      end
      if (ins_valid && op == RETI && m_isr) m_isr = 0;
      if (was_idle && interrupt) m_entering = 1;
    end
  endtask

  // Drive one decode cycle and compute expectations at the sampling edge.
  task automatic apply(input logic r, input logic v, input logic [4:0] op, input logic [7:0] tgt,
                       input logic [7:0] addr, input logic [3:0] fl, input logic irq);
    reset = r; ins_valid = v; ins = {op, 11'h000, tgt}; cur_addr = addr; flag_ex = fl; interrupt = irq;
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b1, JMP, 8'h55, 8'h10, 4'hF, 1'b1);
    advance();
    apply(1'b1, 1'b1, JMP, 8'h55, 8'h10, 4'hF, 1'b1);
    checks++;
    if (pc_mux_sel !== 1'b0 || jmp_loc !== 8'h00 || flag_restore !== 1'b0) begin
      errors++; $display("FAIL reset_comb: sel=%b loc=%h rest=%b, required 0/00/0", pc_mux_sel, jmp_loc, flag_restore);
    end
    advance();
    apply(1'b0, 1'b0, NOP, 8'h00, 8'h00, 4'h0, 1'b0);
    checks++;
    if (in_isr !== 1'b0 || stk_overflow !== 1'b0 || stk_underflow !== 1'b0 || flag_restore_val !== 4'h0) begin
      errors++; $display("FAIL reset_state: isr=%b ovf=%b unf=%b frv=%h, required all 0",
                         in_isr, stk_overflow, stk_underflow, flag_restore_val);
    end
    advance();
  endtask

  task automatic test_cond_branch();
    logic [4:0] ops [5] = '{JMP, JC, JNC, JZ, JNZ};
    apply(1'b0, 1'b1, JC, 8'h40, 8'h10, 4'b0001, 1'b0);
    checks++;
    if (pc_mux_sel !== 1'b1 || jmp_loc !== 8'h40) begin
      errors++; $display("FAIL jc_taken: sel=%b loc=%h, required 1/40", pc_mux_sel, jmp_loc);
    end
    advance();
    apply(1'b0, 1'b1, JC, 8'h40, 8'h10, 4'b0000, 1'b0);
    checks++;
    if (pc_mux_sel !== 1'b0 || jmp_loc !== 8'h00) begin
      errors++; $display("FAIL jc_not_taken: sel=%b loc=%h, required 0/00", pc_mux_sel, jmp_loc);
    end
    advance();
    for (int i = 0; i < 5; i++) begin
      for (int f = 0; f < 4; f++) begin
        apply(1'b0, 1'b1, ops[i], 8'(8'h60 + i * 4 + f), 8'h11, 4'(f), 1'b0);
        checks++;
        if (pc_mux_sel !== exp_sel || jmp_loc !== exp_loc) begin
          errors++; $display("FAIL branch_op%0d_f%0d: sel=%b loc=%h, required %b/%h", i, f, pc_mux_sel, jmp_loc, exp_sel, exp_loc);
        end
        advance();
      end
    end
    apply(1'b0, 1'b0, JMP, 8'h77, 8'h12, 4'h0, 1'b0);
    checks++;
    if (pc_mux_sel !== 1'b0 || jmp_loc !== 8'h00) begin
      errors++; $display("FAIL bubble: sel=%b loc=%h, required 0/00", pc_mux_sel, jmp_loc);
    end
    advance();
  endtask

  task automatic test_call_ret();
    apply(1'b0, 1'b1, CALL, 8'h80, 8'h20, 4'h0, 1'b0);
    checks++;
    if (pc_mux_sel !== 1'b1 || jmp_loc !== 8'h80) begin
      errors++; $display("FAIL call: sel=%b loc=%h, required 1/80", pc_mux_sel, jmp_loc);
    end
    advance();
    apply(1'b0, 1'b1, RET, 8'h00, 8'h81, 4'h0, 1'b0);
    checks++;
    if (pc_mux_sel !== 1'b1 || jmp_loc !== 8'h21) begin
      errors++; $display("FAIL ret: sel=%b loc=%h, required 1/21", pc_mux_sel, jmp_loc);
    end
    advance();
    apply(1'b0, 1'b1, NOP, 8'h00, 8'h21, 4'h0, 1'b0);
    checks++;
    if (stk_underflow !== 1'b0) begin
      errors++; $display("FAIL ret_no_unf: unf=%b, required 0", stk_underflow);
    end
    advance();
  endtask

  task automatic test_overflow();
    apply(1'b1, 1'b0, NOP, 8'h00, 8'h00, 4'h0, 1'b0);
    advance();
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b1, CALL, 8'(8'hA0 + i), 8'(8'h30 + i), 4'h0, 1'b0);
      checks++;
      if (pc_mux_sel !== (i < 4) || jmp_loc !== exp_loc || stk_overflow !== 1'b0) begin
        errors++; $display("FAIL call_fill%0d: sel=%b loc=%h ovf=%b, required %b/%h/0", i, pc_mux_sel, jmp_loc, stk_overflow, i < 4, exp_loc);
      end
      advance();
    end
    for (int i = 3; i >= -1; i--) begin
      apply(1'b0, 1'b1, RET, 8'h00, 8'h50, 4'h0, 1'b0);
      checks++;
      if (stk_overflow !== 1'b1 || pc_mux_sel !== (i >= 0) ||
          (i >= 0 && jmp_loc !== 8'(8'h31 + i)) || stk_underflow !== 1'b0) begin
        errors++; $display("FAIL ret_drain%0d: sel=%b loc=%h ovf=%b unf=%b", i, pc_mux_sel, jmp_loc, stk_overflow, stk_underflow);
      end
      advance();
    end
    apply(1'b0, 1'b0, NOP, 8'h00, 8'h50, 4'h0, 1'b0);
    checks++;
    if (stk_underflow !== 1'b1) begin
      errors++; $display("FAIL underflow_sticky: unf=%b, required 1", stk_underflow);
    end
    advance();
  endtask

  task automatic test_interrupt();
    apply(1'b1, 1'b0, NOP, 8'h00, 8'h00, 4'h0, 1'b0);
    advance();
    apply(1'b0, 1'b1, NOP, 8'h00, 8'h33, 4'b0010, 1'b1);
    advance();
    apply(1'b0, 1'b1, CALL, 8'h99, 8'h33, 4'b0010, 1'b1);
    checks++;
    if (pc_mux_sel !== 1'b1 || jmp_loc !== 8'hF0 || in_isr !== 1'b0) begin
      errors++; $display("FAIL enter: sel=%b loc=%h isr=%b, required 1/F0/0", pc_mux_sel, jmp_loc, in_isr);
    end
    advance();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, NOP, 8'h00, 8'(8'hF0 + i), 4'h5, 1'b1);
      checks++;
      if (in_isr !== 1'b1 || pc_mux_sel !== 1'b0) begin
        errors++; $display("FAIL isr_hold%0d: isr=%b sel=%b, required 1/0", i, in_isr, pc_mux_sel);
      end
      advance();
    end
    apply(1'b0, 1'b1, CALL, 8'h90, 8'hFF, 4'h5, 1'b1);
    advance();
    apply(1'b0, 1'b1, RET, 8'h00, 8'h91, 4'h5, 1'b1);
    checks++;
    if (pc_mux_sel !== 1'b1 || jmp_loc !== 8'h00) begin
      errors++; $display("FAIL call_wrap: sel=%b loc=%h, required 1/00", pc_mux_sel, jmp_loc);
    end
    advance();
    apply(1'b0, 1'b1, RETI, 8'h00, 8'h01, 4'h5, 1'b1);
    checks++;
    if (pc_mux_sel !== 1'b1 || jmp_loc !== 8'h33 || flag_restore !== 1'b1 || flag_restore_val !== 4'b0010) begin
      errors++; $display("FAIL reti: sel=%b loc=%h rest=%b frv=%b, required 1/33/1/0010",
                         pc_mux_sel, jmp_loc, flag_restore, flag_restore_val);
    end
    advance();
    apply(1'b0, 1'b1, NOP, 8'h00, 8'h33, 4'h0, 1'b1);
    checks++;
    if (in_isr !== 1'b0 || pc_mux_sel !== 1'b0 || flag_restore !== 1'b0) begin
      errors++; $display("FAIL post_reti: isr=%b sel=%b rest=%b, required 0/0/0", in_isr, pc_mux_sel, flag_restore);
    end
    advance();
    apply(1'b0, 1'b1, NOP, 8'h00, 8'h34, 4'h0, 1'b0);
    checks++;
    if (pc_mux_sel !== 1'b1 || jmp_loc !== 8'hF0) begin
      errors++; $display("FAIL reentry: sel=%b loc=%h, required 1/F0", pc_mux_sel, jmp_loc);
    end
    advance();
  endtask

  task automatic test_reset_in_enter();
    apply(1'b0, 1'b0, NOP, 8'h00, 8'h44, 4'h3, 1'b1);
    advance();
    apply(1'b0, 1'b0, NOP, 8'h00, 8'h44, 4'h3, 1'b1);
    advance();
    apply(1'b0, 1'b0, NOP, 8'h00, 8'h45, 4'h3, 1'b1);
    advance();
    apply(1'b0, 1'b1, NOP, 8'h00, 8'h50, 4'h3, 1'b1);
    advance();
    apply(1'b1, 1'b1, NOP, 8'h00, 8'h50, 4'h3, 1'b0);
    checks++;
    if (pc_mux_sel !== 1'b0 || jmp_loc !== 8'h00 || flag_restore !== 1'b0) begin
      errors++; $display("FAIL reset_enter: sel=%b loc=%h rest=%b, required 0/00/0", pc_mux_sel, jmp_loc, flag_restore);
    end
    advance();
    apply(1'b0, 1'b1, RETI, 8'h00, 8'h00, 4'h0, 1'b0);
    checks++;
    if (pc_mux_sel !== 1'b0 || flag_restore !== 1'b0 || in_isr !== 1'b0 || flag_restore_val !== 4'h0) begin
      errors++; $display("FAIL reti_nop: sel=%b rest=%b isr=%b frv=%h, required 0/0/0/0",
                         pc_mux_sel, flag_restore, in_isr, flag_restore_val);
    end
    advance();
    apply(1'b0, 1'b1, RET, 8'h00, 8'h01, 4'h0, 1'b0);
    checks++;
    if (pc_mux_sel !== 1'b0) begin
      errors++; $display("FAIL stack_emptied: sel=%b, required 0", pc_mux_sel);
    end
    advance();
  endtask

  task automatic test_random();
    logic [4:0] ops [10] = '{JMP, CALL, JC, JNC, JZ, JNZ, RET, RETI, NOP, 5'b01011};
    for (int n = 0; n < 600; n++) begin
      apply(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) != 0), ops[$urandom_range(0, 9)],
            8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom_range(0, 9) == 0));
      checks++;
      if (pc_mux_sel !== exp_sel || jmp_loc !== exp_loc || flag_restore !== exp_rest ||
          flag_restore_val !== m_flags || in_isr !== m_isr || stk_overflow !== m_ovf ||
          stk_underflow !== m_unf) begin
        errors++;
        $display("FAIL random%0d: sel=%b loc=%h rest=%b frv=%h isr=%b ovf=%b unf=%b, required %b/%h/%b/%h/%b/%b/%b",
                 n, pc_mux_sel, jmp_loc, flag_restore, flag_restore_val, in_isr, stk_overflow, stk_underflow,
                 exp_sel, exp_loc, exp_rest, m_flags, m_isr, m_ovf, m_unf);
      end
      advance();
    end
  endtask

  initial begin
    reset = 1'b1; ins = 24'h000000; ins_valid = 1'b0; cur_addr = 8'h00; flag_ex = 4'h0; interrupt = 1'b0;
    test_reset();
    test_cond_branch();
    test_call_ret();
    test_overflow();
    test_interrupt();
    test_reset_in_enter();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
